win33_g_ctrl: RTL and testbench
===============================

WIN33_G_CTRL -- requirements
Module: win33_g_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: weight memory address width.
REQ-002 SHALL have parameter CNT_W, default 4: width of the kernel-count port.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-006 SHALL have port base_addr, input, ADDR_W bits: address of row 0 of kernel 0, latched at start.
REQ-007 SHALL have port num_kernels, input, CNT_W bits: number of 3x3 kernels in the job, latched at start.
REQ-008 SHALL have port wt_rd_en, output, 1 bit: weight memory read strobe.
REQ-009 SHALL have port wt_addr, output, ADDR_W bits: weight memory read address.
REQ-010 SHALL have port wt_rdata, input, 48 bits: one kernel row {g_1,g_2,g_3}, valid exactly 1 cycle after wt_rd_en.
REQ-011 SHALL have ports kernel1, kernel2, kernel3, outputs, 48 bits each: registered rows 0/1/2 driven to the kernel-transform datapath.
REQ-012 SHALL have ports u_tmp1..u_tmp4, inputs, 64 bits each: combinational transform result rows.
REQ-013 SHALL have port u_data, output, 256 bits: registered {u_tmp1,u_tmp2,u_tmp3,u_tmp4}.
REQ-014 SHALL have port u_idx, output, CNT_W bits: index of the kernel held in u_data.
REQ-015 SHALL have port u_valid, output, 1 bit: u_data valid.
REQ-016 SHALL have port u_ready, input, 1 bit: consumer accepts u_data.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse at job end.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, LAST, XFORM, OUT, DONE.
REQ-020 IDLE: on start=1 with num_kernels!=0, SHALL latch base_addr/num_kernels, clear k=0 and go to FETCH; with num_kernels=0 SHALL go to DONE without any read.
REQ-021 FETCH SHALL last 3 cycles, asserting wt_rd_en with wt_addr = base + 3k + r, r=0,1,2.
REQ-022 Row r data SHALL be captured into kernel(r+1) the cycle after its read; row 2 SHALL be captured in LAST (1 cycle).
REQ-023 XFORM (1 cycle) SHALL register u_tmp1..4 into u_data and k into u_idx, then go to OUT.
REQ-024 OUT SHALL hold u_valid=1 and u_data/u_idx stable until u_ready=1; the handshake completes in the cycle where u_valid & u_ready.
REQ-025 On handshake SHALL go to FETCH with k+1 if k+1 < num_kernels, otherwise to DONE; u_valid SHALL drop the next cycle.
REQ-026 Latency: with start sampled in cycle 0 and u_ready tied high, u_valid SHALL be 1 in cycle 6; kernels SHALL then be delivered at 1 per 6 cycles.
REQ-027 DONE SHALL assert done for exactly 1 cycle and return to IDLE.
REQ-028 start outside IDLE SHALL be ignored, with no effect on latched parameters.
REQ-029 wt_addr arithmetic SHALL be modulo 2^ADDR_W; wrap past the top address SHALL be silent.
REQ-030 wt_rd_en SHALL be 0 in every state except FETCH.
REQ-031 u_ready=1 outside OUT SHALL have no effect.
REQ-032 The block SHALL perform no arithmetic on kernel data; it only registers and forwards it.

Reset
REQ-033 rst=1 SHALL, on the next edge and from any state (including mid-FETCH or OUT), force IDLE.
REQ-034 rst=1 SHALL clear wt_rd_en, u_valid, busy and done to 0.
REQ-035 rst=1 SHALL clear wt_addr, kernel1..3, u_data, u_idx and k to 0.
REQ-036 rst SHALL take priority over start; an interrupted job SHALL NOT pulse done.

Verification
REQ-037 All three rows = {16'd2,16'd2,16'd2}, base=0, num=1, u_ready=1 -> reads at addr 0,1,2; u_valid in cycle 6; u_data = {2,3,1,2 | 3,4,1,3 | 1,1,0,1 | 2,3,1,2}; done pulse in cycle 7.
REQ-038 base=10'h3FE, num=2 -> wt_addr sequence 3FE,3FF,000,001,002,003; u_idx = 0 then 1.
REQ-039 num=3, u_ready held low 5 cycles in each OUT -> u_valid/u_data stable throughout the stall; exactly 3 handshakes; 1 done pulse.
REQ-040 num=0 -> no wt_rd_en; done pulse 1 cycle after start; busy high for 1 cycle.
REQ-041 rst asserted during the 2nd FETCH cycle -> next cycle IDLE with all outputs 0; a fresh start then runs normally from k=0.
REQ-042 start pulsed while in OUT with a different base_addr -> ignored; addresses continue from the original base.

Source files
------------

// File: rtl/win33_g_ctrl.sv
// Purpose: sequences 3x3 kernel rows from weight memory into the kernel-transform datapath and hands out the results.
// Latency: start sampled in cycle 0 -> u_valid in cycle 6; one kernel per 6 cycles while u_ready stays high.
// Backpressure: the OUT state holds u_valid/u_data/u_idx stable until u_ready; no further fetch until the handshake.
module win33_g_ctrl #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_kernels,
  output logic              wt_rd_en,
  output logic [ADDR_W-1:0] wt_addr,
  input  logic [47:0]       wt_rdata,
  output logic [47:0]       kernel1,
  output logic [47:0]       kernel2,
  output logic [47:0]       kernel3,
  input  logic [63:0]       u_tmp1,
  input  logic [63:0]       u_tmp2,
  input  logic [63:0]       u_tmp3,
  input  logic [63:0]       u_tmp4,
  output logic [255:0]      u_data,
  output logic [CNT_W-1:0]  u_idx,
  output logic              u_valid,
  input  logic              u_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LAST,
    S_XFORM,
    S_OUT,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [1:0]        row_q;
  logic [CNT_W-1:0]  k_q;
  logic [CNT_W-1:0]  num_q;
  logic              wt_rd_en_q;
  logic [ADDR_W-1:0] wt_addr_q;
  logic [47:0]       kernel1_q, kernel2_q, kernel3_q;
  logic [255:0]      u_data_q;
  logic [CNT_W-1:0]  u_idx_q;
  logic              u_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [CNT_W:0]    k_d;

  // Next kernel index, one bit wider so the last-kernel compare cannot wrap.
  always_comb begin
    k_d = {1'b0, k_q} + (CNT_W+1)'(1);
  end

  // Job sequencer: the address register walks base+3k+r by simple increments,
  // so wrap past the top of memory falls out of the ADDR_W-bit adder.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= 2'd0;
      k_q        <= '0;
      num_q      <= '0;
      wt_rd_en_q <= 1'b0;
      wt_addr_q  <= '0;
      kernel1_q  <= '0;
      kernel2_q  <= '0;
      kernel3_q  <= '0;
      u_data_q   <= '0;
      u_idx_q    <= '0;
      u_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_q  <= num_kernels;
            k_q    <= '0;
            row_q  <= 2'd0;
            busy_q <= 1'b1;
            if (num_kernels != '0) begin
              wt_addr_q  <= base_addr;
              wt_rd_en_q <= 1'b1;
              state_q    <= S_FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          // Memory returns data one cycle after the strobe: row 0 lands while
          // row 1 is being requested, row 1 while row 2 is requested.
          if (row_q == 2'd1) kernel1_q <= wt_rdata;
          if (row_q == 2'd2) kernel2_q <= wt_rdata;
          if (row_q == 2'd2) begin
            row_q      <= 2'd0;
            wt_rd_en_q <= 1'b0;
            state_q    <= S_LAST;
          end else begin
            row_q     <= row_q + 2'd1;
            wt_addr_q <= wt_addr_q + ADDR_W'(1);
          end
        end
        S_LAST: begin
          kernel3_q <= wt_rdata;
          state_q   <= S_XFORM;
        end
        S_XFORM: begin
          u_data_q  <= {u_tmp1, u_tmp2, u_tmp3, u_tmp4};
          u_idx_q   <= k_q;
          u_valid_q <= 1'b1;
          state_q   <= S_OUT;
        end
        S_OUT: begin
          if (u_ready) begin
            u_valid_q <= 1'b0;
            if (k_d < {1'b0, num_q}) begin
              k_q        <= k_d[CNT_W-1:0];
              wt_addr_q  <= wt_addr_q + ADDR_W'(1);
              wt_rd_en_q <= 1'b1;
              state_q    <= S_FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          wt_rd_en_q <= 1'b0;
          u_valid_q  <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign wt_rd_en = wt_rd_en_q;
  assign wt_addr  = wt_addr_q;
  assign kernel1  = kernel1_q;
  assign kernel2  = kernel2_q;
  assign kernel3  = kernel3_q;
  assign u_data   = u_data_q;
  assign u_idx    = u_idx_q;
  assign u_valid  = u_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_win33_g_ctrl.sv
// Bench for win33_g_ctrl: behavioural weight memory and Winograd G-transform datapath around the DUT,
// randomized jobs checked against an address/data/timing model derived from the job parameters.
module tb_win33_g_ctrl;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_kernels;
  logic              wt_rd_en;
  logic [ADDR_W-1:0] wt_addr;
  logic [47:0]       wt_rdata;
  logic [47:0]       kernel1, kernel2, kernel3;
  logic [63:0]       u_tmp1, u_tmp2, u_tmp3, u_tmp4;
  logic [255:0]      u_data;
  logic [CNT_W-1:0]  u_idx;
  logic              u_valid;
  logic              u_ready;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [47:0] mem [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Weight memory: one-cycle read latency.
  always @(posedge clk) wt_rdata <= wt_rd_en ? mem[wt_addr] : 48'h0;

  // Row transform g -> {g1, (g1+g2+g3)/2, (g1-g2+g3)/2, g3}, floor division.
  function automatic logic [63:0] xr(input logic [47:0] row);
    logic signed [17:0] a, b, c, s, d;
    a = $signed(row[47:32]);
    b = $signed(row[31:16]);
    c = $signed(row[15:0]);
    s = a + b + c;
    d = a - b + c;
    return {row[47:32], s[16:1], d[16:1], row[15:0]};
  endfunction

  // Column-wise combination of three rows: (x+y+z)/2 or (x-y+z)/2 per element.
  function automatic logic [47:0] rmix(input logic [47:0] x, input logic [47:0] y,
                                       input logic [47:0] z, input logic neg);
    logic signed [17:0] a, b, c, s;
    logic [47:0] o;
    o = '0;
    for (int j = 0; j < 3; j++) begin
      a = $signed(x[16*j +: 16]);
      b = $signed(y[16*j +: 16]);
      c = $signed(z[16*j +: 16]);
      s = neg ? (a - b + c) : (a + b + c);
      o[16*j +: 16] = s[16:1];
    end
    return o;
  endfunction

  function automatic logic [255:0] winograd(input logic [47:0] r0, input logic [47:0] r1,
                                            input logic [47:0] r2);
    return {xr(r0), xr(rmix(r0, r1, r2, 1'b0)), xr(rmix(r0, r1, r2, 1'b1)), xr(r2)};
  endfunction

  assign u_tmp1 = xr(kernel1);
  assign u_tmp2 = xr(rmix(kernel1, kernel2, kernel3, 1'b0));
  assign u_tmp3 = xr(rmix(kernel1, kernel2, kernel3, 1'b1));
  assign u_tmp4 = xr(kernel3);

  win33_g_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_kernels(num_kernels),
    .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_rdata(wt_rdata),
    .kernel1(kernel1), .kernel2(kernel2), .kernel3(kernel3),
    .u_tmp1(u_tmp1), .u_tmp2(u_tmp2), .u_tmp3(u_tmp3), .u_tmp4(u_tmp4),
    .u_data(u_data), .u_idx(u_idx), .u_valid(u_valid), .u_ready(u_ready),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, wt_rd_en, 0);
    check({tag, "_addr"},  wt_addr, 0);
    check({tag, "_k1"},    kernel1, 0);
    check({tag, "_k2"},    kernel2, 0);
    check({tag, "_k3"},    kernel3, 0);
    check({tag, "_udata"}, u_data, 0);
    check({tag, "_uidx"},  u_idx, 0);
    check({tag, "_uvld"},  u_valid, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
  endtask

  // mode 0: u_ready tied high; 1: u_ready low for 5 cycles in each OUT; 2: random u_ready.
  task automatic run_job(input logic [ADDR_W-1:0] base, input int num, input int mode,
                         input bit inject, output logic [255:0] last_dat);
    int start_cyc, done_cyc, first_valid, n_done, n_busy, stall, nr;
    logic [ADDR_W-1:0] rd_q[$];
    logic [255:0]      hs_dat[$];
    int                hs_idx[$];
    bit                prev_stall, prev_hs;
    logic [255:0]      prev_dat;
    logic [CNT_W-1:0]  prev_idx;
    logic [ADDR_W-1:0] a;
    done_cyc = -1; first_valid = -1; n_done = 0; n_busy = 0; stall = 0;
    prev_stall = 1'b0; prev_hs = 1'b0; prev_dat = '0; prev_idx = '0;

    @(posedge clk); #1;
    start       = 1'b1;
    base_addr   = base;
    num_kernels = CNT_W'(num);
    u_ready     = (mode == 0);
    start_cyc   = cyc;

    for (int t = 0; t < 600 && done_cyc < 0; t++) begin
      @(negedge clk);
      if (cyc > start_cyc) begin
        if (busy) n_busy++;
        if (wt_rd_en) rd_q.push_back(wt_addr);
        if (u_valid && first_valid < 0) first_valid = cyc;
        if (prev_stall) begin
          check("stall_hold_vld", u_valid, 1);
          check("stall_hold_dat", u_data, prev_dat);
          check("stall_hold_idx", u_idx, prev_idx);
        end
        if (prev_hs) check("vld_drop_after_hs", u_valid, 0);
        prev_stall = u_valid && !u_ready;
        prev_hs    = u_valid && u_ready;
        prev_dat   = u_data;
        prev_idx   = u_idx;
        if (prev_hs) begin
          hs_dat.push_back(u_data);
          hs_idx.push_back(int'(u_idx));
        end
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
      end
      @(posedge clk); #1;
      start       = inject && busy && !done && ($urandom_range(0, 3) == 0);
      base_addr   = ADDR_W'($urandom);
      num_kernels = CNT_W'($urandom);
      case (mode)
        0: u_ready = 1'b1;
        1: begin
          if (u_valid) begin
            if (stall < 5) begin u_ready = 1'b0; stall++; end
            else begin u_ready = 1'b1; stall = 0; end
          end else begin
            u_ready = 1'($urandom_range(0, 1));
          end
        end
        default: u_ready = 1'($urandom_range(0, 1));
      endcase
    end
    start = 1'b0;

    check("done_pulses", n_done, 1);
    check("n_reads", rd_q.size(), 3 * num);
    nr = (rd_q.size() < 3 * num) ? rd_q.size() : 3 * num;
    for (int i = 0; i < nr; i++) check("rd_addr", rd_q[i], ADDR_W'(base + ADDR_W'(i)));
    check("n_handshakes", hs_dat.size(), num);
    for (int k = 0; k < num && k < hs_dat.size(); k++) begin
      a = base + ADDR_W'(3 * k);
      check("u_data", hs_dat[k], winograd(mem[a], mem[ADDR_W'(a + 1)], mem[ADDR_W'(a + 2)]));
      check("u_idx", hs_idx[k], k);
    end
    if (num > 0) check("first_valid_latency", first_valid - start_cyc, 6);
    if (mode == 0) check("done_cycle", done_cyc - start_cyc, (num == 0) ? 1 : 1 + 6 * num);
    check("busy_cycles", n_busy, done_cyc - start_cyc);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_rd_en", wt_rd_en, 0);
    end
    last_dat = (hs_dat.size() > 0) ? hs_dat[hs_dat.size() - 1] : '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [255:0] dat;
    logic [255:0] req_ones;
    int           sc;
    rst = 1'b1; start = 1'b0; base_addr = '0; num_kernels = '0; u_ready = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 48'({$urandom(), $urandom()});

    // Reset state, with start asserted to confirm reset wins.
    repeat (2) @(posedge clk);
    #1 start = 1'b1; num_kernels = 4'd3;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;

    // All-2 kernel at base 0, one kernel.
    mem[0] = {16'd2, 16'd2, 16'd2};
    mem[1] = {16'd2, 16'd2, 16'd2};
    mem[2] = {16'd2, 16'd2, 16'd2};
    run_job(10'd0, 1, 0, 1'b0, dat);
    req_ones = {16'd2, 16'd3, 16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd3,
                16'd1, 16'd1, 16'd0, 16'd1, 16'd2, 16'd3, 16'd1, 16'd2};
    check("all2_u_data", dat, req_ones);

    // Address wrap at the top of memory.
    run_job(10'h3FE, 2, 0, 1'b0, dat);

    // Stalled consumer.
    run_job(ADDR_W'($urandom), 3, 1, 1'b0, dat);

    // Empty job.
    run_job(ADDR_W'($urandom), 0, 0, 1'b0, dat);

    // Reset during the second FETCH cycle.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'h123; num_kernels = 4'd2; u_ready = 1'b1;
    sc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("rst_in_fetch2", cyc - sc, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    run_job(ADDR_W'($urandom), 2, 0, 1'b0, dat);

    // Spurious starts with new base while the job is running.
    run_job(ADDR_W'($urandom), 3, 2, 1'b1, dat);

    // Randomized jobs.
    for (int j = 0; j < 10; j++)
      run_job(ADDR_W'($urandom), $urandom_range(0, 5), $urandom_range(0, 2), 1'b1, dat);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
